// File: rtl/tl_pkg.sv
// Shared types and default timing for the two-street intersection controller.
package tl_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'b00,
      YELLOW = 2'b01,
      RED    = 2'b10
   } light_t;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } lstate_t;

   localparam int YELLOW_CYC_DEF = 5;
   localparam int MIN_GREEN_DEF  = 4;
   localparam int TIMER_W_DEF    = 4;

endpackage

// File: rtl/phase_timer.sv
// Cycles-in-phase counter: synchronous clear, saturates at all-ones, async reset.
module phase_timer #(
   parameter int TIMER_W = 4
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               clear,
   output logic [TIMER_W-1:0] count
);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (count != {TIMER_W{1'b1}})
         count <= count + 1'b1;
   end

endmodule

// File: rtl/traffic_light_controller.sv
// Academic/Bravo light sequencer with parade hold; Moore outputs from the light state,
// phase timing from phase_timer, parade mode registered before it steers the FSM.
module traffic_light_controller
   import tl_pkg::*;
#(
   parameter int YELLOW_CYC = YELLOW_CYC_DEF,
   parameter int MIN_GREEN  = MIN_GREEN_DEF,
   parameter int TIMER_W    = TIMER_W_DEF
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       TA,
   input  logic       TB,
   input  logic       P,
   input  logic       R,
   output logic [1:0] LA,
   output logic [1:0] LB,
   output logic       M,
   output logic [1:0] phase
);

   localparam logic [TIMER_W-1:0] GMIN_LAST = TIMER_W'(MIN_GREEN - 1);
   localparam logic [TIMER_W-1:0] YEL_LAST  = TIMER_W'(YELLOW_CYC - 1);

   lstate_t            state;
   lstate_t            state_nxt;
   logic [TIMER_W-1:0] timer;
   logic               timer_clr;
   logic               gmin;
   logic               ydone;
   light_t             la;
   light_t             lb;

   // P and R together toggle; otherwise P sets and R clears.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         M <= 1'b0;
      else if (P && R)
         M <= ~M;
      else if (P)
         M <= 1'b1;
      else if (R)
         M <= 1'b0;
   end

   // >= keeps green exits possible once the timer has saturated.
   assign gmin  = (timer >= GMIN_LAST);
   assign ydone = (timer == YEL_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         S0:      if (gmin && (!TA || M))  state_nxt = S1;
         S1:      if (ydone)               state_nxt = S2;
         S2:      if (gmin && !M && !TB)   state_nxt = S3;
         S3:      if (ydone)               state_nxt = S0;
         default:                          state_nxt = S0;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         state <= S0;
      else
         state <= state_nxt;
   end

   assign timer_clr = (state_nxt != state);

   phase_timer #(
      .TIMER_W (TIMER_W)
   ) u_timer (
      .CLK   (CLK),
      .reset (reset),
      .clear (timer_clr),
      .count (timer)
   );

   always_comb begin
      la = RED;
      lb = RED;
      case (state)
         S0:      la = GREEN;
         S1:      la = YELLOW;
         S2:      lb = GREEN;
         S3:      lb = YELLOW;
         default: la = RED;
      endcase
   end

   assign LA    = la;
   assign LB    = lb;
   assign phase = state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed and random stimulus against a duration-based reference model of the intersection.
module tb_traffic_light_controller;

   localparam int YC = 5;
   localparam int MG = 4;

   logic       CLK;
   logic       reset;
   logic       TA, TB, P, R;
   logic [1:0] LA, LB, phase;
   logic       M;

   int errors = 0;
   int checks = 0;

   // Reference model: which phase we are in, how many cycles it has been held, parade flag.
   int m_state;
   int m_age;
   bit m_mode;

   traffic_light_controller #(
      .YELLOW_CYC (YC),
      .MIN_GREEN  (MG),
      .TIMER_W    (4)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .TA    (TA),
      .TB    (TB),
      .P     (P),
      .R     (R),
      .LA    (LA),
      .LB    (LB),
      .M     (M),
      .phase (phase)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic int exp_la(input int s);
      return (s == 0) ? 0 : (s == 1) ? 1 : 2;
   endfunction

   function automatic int exp_lb(input int s);
      return (s == 2) ? 0 : (s == 3) ? 1 : 2;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_LA"},    int'(LA),    exp_la(m_state));
      chk({tag, "_LB"},    int'(LB),    exp_lb(m_state));
      chk({tag, "_M"},     int'(M),     int'(m_mode));
      chk({tag, "_phase"}, int'(phase), m_state);
   endtask

   task automatic model_reset();
      m_state = 0;
      m_age   = 1;
      m_mode  = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare just after it.
   task automatic step(input logic ta, input logic tb, input logic p, input logic r);
      bit leave;
      bit nxt_mode;
      TA = ta; TB = tb; P = p; R = r;
      @(posedge CLK);
      if (p && r)      nxt_mode = !m_mode;
      else if (p)      nxt_mode = 1'b1;
      else if (r)      nxt_mode = 1'b0;
      else             nxt_mode = m_mode;
      case (m_state)
         0:       leave = (m_age >= MG) && (!ta || m_mode);
         1:       leave = (m_age == YC);
         2:       leave = (m_age >= MG) && !m_mode && !tb;
         default: leave = (m_age == YC);
      endcase
      if (leave) begin
         m_state = (m_state + 1) % 4;
         m_age   = 1;
      end else begin
         m_age++;
      end
      m_mode = nxt_mode;
      #1;
      chk_all("cyc");
   endtask

   // Edges needed until the phase changes, bounded so a stuck DUT still ends.
   task automatic measure(input logic ta, input logic tb, input logic p, input logic r,
                          output int n);
      logic [1:0] start;
      start = phase;
      n = 0;
      do begin
         step(ta, tb, p, r);
         n++;
      end while (phase == start && n < 200);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(posedge CLK);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      TA = 1'b1; TB = 1'b1; P = 1'b0; R = 1'b0;
      model_reset();

      // Outputs while reset is held with traffic on both streets.
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_LA", int'(LA), 0);
      chk("rst_LB", int'(LB), 2);
      chk("rst_M", int'(M), 0);
      chk("rst_phase", int'(phase), 0);
      reset = 1'b0;
      repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("ta_hold_phase", int'(phase), 0);

      // A to B handoff: TA drops after 10 cycles with TB present.
      do_reset();
      repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("handoff_phase", int'(phase), 1);
      measure(1'b0, 1'b1, 1'b0, 1'b0, n);
      chk("handoff_yel_len", n, YC);
      repeat (25) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("handoff_s2_hold", int'(phase), 2);

      // Minimum green from reset release.
      do_reset();
      measure(1'b0, 1'b1, 1'b0, 1'b0, n);
      chk("mingreen_s0_len", n, MG);
      measure(1'b0, 1'b1, 1'b0, 1'b0, n);
      chk("mingreen_s1_len", n, YC);
      chk("mingreen_s2", int'(phase), 2);

      // Parade hold and release.
      do_reset();
      repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("parade_M_set", int'(M), 1);
      measure(1'b1, 1'b0, 1'b0, 1'b0, n);
      chk("parade_s1", int'(phase), 1);
      measure(1'b1, 1'b0, 1'b0, 1'b0, n);
      chk("parade_s1_len", n, YC);
      repeat (60) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("parade_s2_hold", int'(phase), 2);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("parade_M_clr", int'(M), 0);
      chk("parade_still_s2", int'(phase), 2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("parade_s3", int'(phase), 3);
      measure(1'b1, 1'b0, 1'b0, 1'b0, n);
      chk("parade_s3_len", n, YC);
      chk("parade_back_s0", int'(phase), 0);

      // Simultaneous P and R toggle; P held keeps parade set.
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("pr_set", int'(M), 1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("pr_clr", int'(M), 0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("p_held", int'(M), 1);
      step(1'b1, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset in the third cycle of the Bravo yellow.
      do_reset();
      measure(1'b0, 1'b0, 1'b0, 1'b0, n);
      measure(1'b0, 1'b0, 1'b0, 1'b0, n);
      measure(1'b0, 1'b0, 1'b0, 1'b0, n);
      chk("midyel_in_s3", int'(phase), 3);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      chk("midyel_LA", int'(LA), 0);
      chk("midyel_LB", int'(LB), 2);
      chk("midyel_phase", int'(phase), 0);
      chk("midyel_timer", int'(dut.u_timer.count), 0);
      do_reset();

      // Random traffic with occasional parade requests.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(15) == 0), 1'($urandom_range(7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
